// File: rtl/cache_controller_if.sv
// cache_controller_if: CPU request/response channel and main-memory word-transfer channel
// for cache_controller.
//   req_valid/req_ready  CPU request handshake; req_write, req_addr, req_wdata describe it.
//   resp_valid           one-cycle completion pulse; resp_rdata carries load data.
//   mem_req              memory transfer active; mem_read_write 1 = write, 0 = read.
//   mem_addr, mem_wdata  word-aligned address and writeback data.
//   mem_rdata, mem_done  refill data and per-word completion from memory.
// Modport master is the controller side; slave is the CPU/memory environment side.
interface cache_controller_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  req_ready;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  mem_req;
  logic                  mem_read_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_done;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_done,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_read_write, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_done,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_read_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-back, write-allocate cache between the CPU data port
// and a byte-addressed main memory. Owns tag/valid/dirty/data arrays, moves whole blocks
// word-by-word on the memory channel and keeps saturating hit/miss counters.
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   bus         cache_controller_if.master (CPU request/response + memory transfer)
//   hit_count   first-pass hits, saturating at 0xFFFF
//   miss_count  misses, saturating at 0xFFFF
module cache_controller #(
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned NUM_LINES       = 4,
  parameter int unsigned WORDS_PER_BLOCK = 4
) (
  input  logic                clock,
  input  logic                reset,
  cache_controller_if.master  bus,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
);
  localparam int unsigned OffW      = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IdxW      = $clog2(NUM_LINES);
  localparam int unsigned WordAddrW = ADDR_WIDTH - 2;
  localparam int unsigned TagW      = WordAddrW - IdxW - OffW;

  typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StAllocate} state_t;
  state_t stateQ, stateD;

  logic                 reqWriteQ;
  logic [WordAddrW-1:0] reqWordQ;
  logic [31:0]          reqWdataQ;
  logic                 refilledQ;   // set once the line was just refilled for this request
  logic [OffW-1:0]      cntQ;
  logic [TagW-1:0]      tagQ  [NUM_LINES];
  logic [NUM_LINES-1:0] validQ;
  logic [NUM_LINES-1:0] dirtyQ;
  logic [31:0]          dataQ [NUM_LINES][WORDS_PER_BLOCK];
  logic [15:0]          hitCountQ;
  logic [15:0]          missCountQ;

  logic [OffW-1:0] woff;
  logic [IdxW-1:0] idx;
  logic [TagW-1:0] reqTag;
  logic            hit;
  logic            lastWord;
  logic            unusedAddrBits;

  // Word access only: the byte offset is dropped when the request is latched.
  assign unusedAddrBits = ^bus.req_addr[1:0];

  assign woff     = reqWordQ[OffW-1:0];
  assign idx      = reqWordQ[OffW +: IdxW];
  assign reqTag   = reqWordQ[WordAddrW-1 -: TagW];
  assign hit      = validQ[idx] && (tagQ[idx] == reqTag);
  assign lastWord = (cntQ == OffW'(WORDS_PER_BLOCK - 1));

  assign hit_count  = hitCountQ;
  assign miss_count = missCountQ;

  always_ff @(posedge clock) begin
    if (reset) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:      if (bus.req_valid) stateD = StCompare;
      StCompare: begin
        if (hit)                            stateD = StIdle;
        else if (validQ[idx] && dirtyQ[idx]) stateD = StWriteback;
        else                                stateD = StAllocate;
      end
      StWriteback: if (bus.mem_done && lastWord) stateD = StAllocate;
      StAllocate:  if (bus.mem_done && lastWord) stateD = StCompare;
      default:     stateD = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_rdata     = '0;
    bus.mem_req        = 1'b0;
    bus.mem_read_write = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    unique case (stateQ)
      StIdle: bus.req_ready = 1'b1;
      StCompare: begin
        bus.resp_valid = hit;
        if (hit && !reqWriteQ) bus.resp_rdata = dataQ[idx][woff];
      end
      StWriteback: begin
        bus.mem_req        = 1'b1;
        bus.mem_read_write = 1'b1;
        bus.mem_addr       = {tagQ[idx], idx, cntQ, 2'b00};
        bus.mem_wdata      = dataQ[idx][cntQ];
      end
      StAllocate: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {reqTag, idx, cntQ, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      reqWriteQ  <= 1'b0;
      reqWordQ   <= '0;
      reqWdataQ  <= '0;
      refilledQ  <= 1'b0;
      cntQ       <= '0;
      validQ     <= '0;
      dirtyQ     <= '0;
      hitCountQ  <= '0;
      missCountQ <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tagQ[i] <= '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) dataQ[i][w] <= '0;
      end
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (bus.req_valid) begin
            reqWriteQ <= bus.req_write;
            reqWordQ  <= bus.req_addr[ADDR_WIDTH-1:2];
            reqWdataQ <= bus.req_wdata;
            refilledQ <= 1'b0;
          end
        end
        StCompare: begin
          if (hit) begin
            if (reqWriteQ) begin
              dataQ[idx][woff] <= reqWdataQ;
              dirtyQ[idx]      <= 1'b1;
            end
            // The re-compare after a refill completes a miss, not a hit.
            if (!refilledQ && (hitCountQ != 16'hFFFF)) hitCountQ <= hitCountQ + 16'd1;
          end else begin
            if (missCountQ != 16'hFFFF) missCountQ <= missCountQ + 16'd1;
            cntQ <= '0;
          end
        end
        StWriteback: begin
          if (bus.mem_done) cntQ <= lastWord ? '0 : cntQ + OffW'(1);
        end
        StAllocate: begin
          if (bus.mem_done) begin
            dataQ[idx][cntQ] <= bus.mem_rdata;
            cntQ             <= lastWord ? '0 : cntQ + OffW'(1);
            if (lastWord) begin
              tagQ[idx]   <= reqTag;
              validQ[idx] <= 1'b1;
              dirtyQ[idx] <= 1'b0;
              refilledQ   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed self-checking bench for cache_controller with a 256-word
// memory model whose mem_done can be stretched by a programmable number of cycles.
module tb_cache_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cache_controller_if #(.ADDR_WIDTH(10)) bus ();
  logic [15:0] hitCount;
  logic [15:0] missCount;

  cache_controller #(
    .ADDR_WIDTH(10),
    .NUM_LINES(4),
    .WORDS_PER_BLOCK(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .hit_count(hitCount),
    .miss_count(missCount)
  );

  int passed = 0;
  int total = 0;
  int stallCycles = 0;

  // Memory model and bus monitors.
  logic [31:0] tbMem [256];
  logic        memLoaded = 1'b0;
  int          stallCnt = 0;
  logic [9:0]  rdLog [128];
  int          rdN = 0;
  logic [9:0]  wrAddrLog [128];
  logic [31:0] wrDataLog [128];
  int          wrN = 0;
  int          memReqCycles = 0;
  int          respCount = 0;
  int          stableErr = 0;
  logic        stalledPrev = 1'b0;
  logic [9:0]  prevAddr = '0;

  assign bus.mem_done  = (stallCnt == stallCycles);
  assign bus.mem_rdata = tbMem[bus.mem_addr[9:2]];

  always @(posedge clock) begin
    if (!memLoaded) begin
      for (int i = 0; i < 256; i++)
        tbMem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
      memLoaded <= 1'b1;
    end else if (bus.mem_req && bus.mem_done && bus.mem_read_write) begin
      tbMem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    if (bus.mem_req) begin
      memReqCycles <= memReqCycles + 1;
      stallCnt     <= bus.mem_done ? 0 : stallCnt + 1;
    end else begin
      stallCnt <= 0;
    end
    if (bus.mem_req && bus.mem_done) begin
      if (bus.mem_read_write) begin
        if (wrN < 128) begin
          wrAddrLog[wrN] <= bus.mem_addr;
          wrDataLog[wrN] <= bus.mem_wdata;
        end
        wrN <= wrN + 1;
      end else begin
        if (rdN < 128) rdLog[rdN] <= bus.mem_addr;
        rdN <= rdN + 1;
      end
    end
    if (stalledPrev && bus.mem_req && (bus.mem_addr != prevAddr)) stableErr <= stableErr + 1;
    stalledPrev <= bus.mem_req && !bus.mem_done;
    prevAddr    <= bus.mem_addr;
    if (bus.resp_valid) respCount <= respCount + 1;
  end

  // Issue one request from Idle; lat is the cycle (accept edge = 0) in which resp_valid is
  // seen, 0 on timeout. Returns at the negedge after the response, back in Idle.
  task automatic doReq(input logic w, input logic [9:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd);
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h3FF;
    bus.req_wdata = 32'hBAD0BAD0;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (bus.resp_valid) begin
        lat = i;
        rd  = bus.resp_rdata;
        break;
      end
    end
    if (lat == 0) $display("FAIL req_timeout: no resp_valid within 100 cycles for addr %h", a);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); else passed++;
    total++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); else passed++;
    total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); else passed++;
    total++; if (bus.mem_read_write !== 1'b0) $display("FAIL reset_mem_rw: got %b expected 0", bus.mem_read_write); else passed++;
    total++; if (bus.mem_addr !== 10'h0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else passed++;
    total++; if (bus.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); else passed++;
    total++; if (hitCount !== 16'h0) $display("FAIL reset_hit_count: got %h expected 0", hitCount); else passed++;
    total++; if (missCount !== 16'h0) $display("FAIL reset_miss_count: got %h expected 0", missCount); else passed++;
  endtask

  task automatic test_clean_miss();
    int lat;
    logic [31:0] rd;
    int r0 = rdN;
    int w0 = wrN;
    doReq(1'b0, 10'h040, 32'h0, lat, rd);
    total++; if (lat !== 6) $display("FAIL clean_miss_latency: got %0d expected 6", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL clean_miss_rdata: got %h expected deadbeef", rd); else passed++;
    total++; if (missCount !== 16'd1) $display("FAIL clean_miss_miss_count: got %0d expected 1", missCount); else passed++;
    total++; if (hitCount !== 16'd0) $display("FAIL clean_miss_hit_count: got %0d expected 0", hitCount); else passed++;
    total++; if (rdN - r0 !== 4) $display("FAIL clean_miss_reads: got %0d expected 4", rdN - r0); else passed++;
    total++; if (wrN - w0 !== 0) $display("FAIL clean_miss_writes: got %0d expected 0", wrN - w0); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rdLog[r0+k] !== 10'(10'h040 + 4 * k))
        $display("FAIL clean_miss_read_addr%0d: got %h expected %h", k, rdLog[r0+k], 10'(10'h040 + 4 * k));
      else passed++;
    end
  endtask

  task automatic test_hit();
    int lat;
    logic [31:0] rd;
    int m0 = memReqCycles;
    doReq(1'b0, 10'h048, 32'h0, lat, rd);
    total++; if (lat !== 1) $display("FAIL hit_latency: got %0d expected 1", lat); else passed++;
    total++; if (rd !== 32'hC0DE0012) $display("FAIL hit_rdata: got %h expected c0de0012", rd); else passed++;
    total++; if (hitCount !== 16'd1) $display("FAIL hit_hit_count: got %0d expected 1", hitCount); else passed++;
    total++; if (memReqCycles - m0 !== 0) $display("FAIL hit_mem_req: got %0d cycles expected 0", memReqCycles - m0); else passed++;
  endtask

  task automatic test_writeback();
    int lat;
    logic [31:0] rd;
    int r0;
    int w0;
    logic [31:0] expData [4];
    expData[0] = 32'hDEADBEEF;
    expData[1] = 32'h12345678;
    expData[2] = 32'hC0DE0012;
    expData[3] = 32'hC0DE0013;
    doReq(1'b1, 10'h044, 32'h12345678, lat, rd);
    total++; if (lat !== 1) $display("FAIL store_hit_latency: got %0d expected 1", lat); else passed++;
    total++; if (hitCount !== 16'd2) $display("FAIL store_hit_count: got %0d expected 2", hitCount); else passed++;
    r0 = rdN;
    w0 = wrN;
    doReq(1'b0, 10'h144, 32'h0, lat, rd);
    total++; if (lat !== 10) $display("FAIL dirty_miss_latency: got %0d expected 10", lat); else passed++;
    total++; if (rd !== 32'hC0DE0051) $display("FAIL dirty_miss_rdata: got %h expected c0de0051", rd); else passed++;
    total++; if (wrN - w0 !== 4) $display("FAIL dirty_miss_writes: got %0d expected 4", wrN - w0); else passed++;
    total++; if (rdN - r0 !== 4) $display("FAIL dirty_miss_reads: got %0d expected 4", rdN - r0); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (wrAddrLog[w0+k] !== 10'(10'h040 + 4 * k))
        $display("FAIL wb_addr%0d: got %h expected %h", k, wrAddrLog[w0+k], 10'(10'h040 + 4 * k));
      else passed++;
      total++;
      if (wrDataLog[w0+k] !== expData[k])
        $display("FAIL wb_data%0d: got %h expected %h", k, wrDataLog[w0+k], expData[k]);
      else passed++;
      total++;
      if (rdLog[r0+k] !== 10'(10'h140 + 4 * k))
        $display("FAIL refill_addr%0d: got %h expected %h", k, rdLog[r0+k], 10'(10'h140 + 4 * k));
      else passed++;
    end
    total++; if (tbMem[17] !== 32'h12345678) $display("FAIL wb_mem_044: got %h expected 12345678", tbMem[17]); else passed++;
    total++; if (missCount !== 16'd2) $display("FAIL dirty_miss_miss_count: got %0d expected 2", missCount); else passed++;
    total++; if (hitCount !== 16'd2) $display("FAIL dirty_miss_hit_count: got %0d expected 2", hitCount); else passed++;
  endtask

  task automatic test_stall();
    int lat;
    logic [31:0] rd;
    int r0 = rdN;
    int se0 = stableErr;
    stallCycles = 3;
    doReq(1'b0, 10'h0C0, 32'h0, lat, rd);
    stallCycles = 0;
    total++; if (lat !== 18) $display("FAIL stall_latency: got %0d expected 18", lat); else passed++;
    total++; if (rd !== 32'hC0DE0030) $display("FAIL stall_rdata: got %h expected c0de0030", rd); else passed++;
    total++; if (stableErr - se0 !== 0) $display("FAIL stall_addr_stable: got %0d changes expected 0", stableErr - se0); else passed++;
    total++; if (rdN - r0 !== 4) $display("FAIL stall_reads: got %0d expected 4", rdN - r0); else passed++;
    total++; if (missCount !== 16'd3) $display("FAIL stall_miss_count: got %0d expected 3", missCount); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int rc0;
    logic [31:0] rd;
    doReq(1'b1, 10'h0C4, 32'hA5A50C04, lat, rd);
    total++; if (lat !== 1) $display("FAIL dirty_store_latency: got %0d expected 1", lat); else passed++;
    rc0 = respCount;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h104;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clock);  // compare
    @(negedge clock);  // writeback word 0
    @(negedge clock);  // writeback word 1
    total++; if (bus.mem_req !== 1'b1) $display("FAIL mid_wb_mem_req: got %b expected 1", bus.mem_req); else passed++;
    total++; if (bus.mem_addr !== 10'h0C4) $display("FAIL mid_wb_addr: got %h expected 0c4", bus.mem_addr); else passed++;
    total++; if (bus.mem_wdata !== 32'hA5A50C04) $display("FAIL mid_wb_wdata: got %h expected a5a50c04", bus.mem_wdata); else passed++;
    reset = 1'b1;
    @(negedge clock);
    total++; if (bus.mem_req !== 1'b0) $display("FAIL abort_mem_req: got %b expected 0", bus.mem_req); else passed++;
    total++; if (bus.req_ready !== 1'b1) $display("FAIL abort_req_ready: got %b expected 1", bus.req_ready); else passed++;
    total++; if (bus.resp_valid !== 1'b0) $display("FAIL abort_resp_valid: got %b expected 0", bus.resp_valid); else passed++;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (respCount - rc0 !== 0) $display("FAIL abort_no_resp: got %0d responses expected 0", respCount - rc0); else passed++;
    total++; if (missCount !== 16'd0) $display("FAIL abort_miss_count: got %0d expected 0", missCount); else passed++;
    total++; if (hitCount !== 16'd0) $display("FAIL abort_hit_count: got %0d expected 0", hitCount); else passed++;
    doReq(1'b0, 10'h0C4, 32'h0, lat, rd);
    total++; if (lat !== 6) $display("FAIL reload_latency: got %0d expected 6", lat); else passed++;
    total++; if (rd !== 32'hA5A50C04) $display("FAIL reload_rdata: got %h expected a5a50c04", rd); else passed++;
    total++; if (missCount !== 16'd1) $display("FAIL reload_miss_count: got %0d expected 1", missCount); else passed++;
  endtask

  task automatic test_saturation();
    int lat;
    logic [31:0] rd;
    @(negedge clock);
    force dut.hitCountQ = 16'hFFFE;
    #1;
    release dut.hitCountQ;
    doReq(1'b0, 10'h0C4, 32'h0, lat, rd);
    total++; if (hitCount !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", hitCount); else passed++;
    doReq(1'b0, 10'h0C8, 32'h0, lat, rd);
    total++; if (lat !== 1) $display("FAIL sat_hit_latency: got %0d expected 1", lat); else passed++;
    total++; if (rd !== 32'hC0DE0032) $display("FAIL sat_rdata: got %h expected c0de0032", rd); else passed++;
    total++; if (hitCount !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", hitCount); else passed++;
    total++; if (missCount !== 16'd1) $display("FAIL sat_miss_count: got %0d expected 1", missCount); else passed++;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_clean_miss();
    test_hit();
    test_writeback();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
